// File: rtl/display_scanner.sv
// display_scanner
//   Time-multiplexes three seven-segment codes onto one shared segment bus
//   with one-hot digit enables. Codes are snapshotted once per frame so a
//   frame never mixes old and new values; leading zeros on the minutes and
//   tens digits can be blanked; each digit slot opens with an all-off guard
//   interval to suppress ghosting on the panel.
//
//   Ports:
//     clock          system clock, rising edge
//     resetn         synchronous active-low reset
//     sec_ones_segs  gfedcba code for digit 0
//     sec_tens_segs  gfedcba code for digit 1
//     min_segs       gfedcba code for digit 2
//     segs           shared segment bus, gfedcba, active-high (registered)
//     digit_en       one-hot digit enable, bit0 = sec_ones (registered)
//
//   digit ring:
//     state | meaning
//     0     | sec_ones slot (frame start, snapshot taken at div_cnt 0)
//     1     | sec_tens slot
//     2     | min slot
//     3     | illegal, recovers to 0 on the next cycle
module display_scanner #(
  parameter int REFRESH_DIV   = 50000,
  parameter int GUARD         = 4,
  parameter int BLANK_LEADING = 1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [6:0] sec_ones_segs,
  input  logic [6:0] sec_tens_segs,
  input  logic [6:0] min_segs,
  output logic [6:0] segs,
  output logic [2:0] digit_en
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
  localparam logic [6:0]    ZERO    = 7'b0111111;

  logic [CW-1:0] div_cnt;
  logic [1:0]    digit;
  logic [6:0]    snap0, snap1, snap2;

  logic          slot_end;
  logic          frame_start;
  logic          blank1, blank2;
  logic          sel_blank;
  logic [2:0]    sel_en;
  logic [6:0]    sel_segs;
  logic          show;

  assign slot_end    = (div_cnt == CNT_MAX);
  assign frame_start = (digit == 2'd0) && (div_cnt == '0);

  // Blanking works from the snapshot, so it is as frame-coherent as the codes.
  assign blank2 = (BLANK_LEADING != 0) && (snap2 == ZERO);
  assign blank1 = blank2 && (snap1 == ZERO);

  always_comb begin
    sel_en    = 3'b000;
    sel_segs  = 7'd0;
    sel_blank = 1'b1;
    case (digit)
      2'd0: begin sel_en = 3'b001; sel_segs = snap0; sel_blank = 1'b0;   end
      2'd1: begin sel_en = 3'b010; sel_segs = snap1; sel_blank = blank1; end
      2'd2: begin sel_en = 3'b100; sel_segs = snap2; sel_blank = blank2; end
      default: begin sel_en = 3'b000; sel_segs = 7'd0; sel_blank = 1'b1; end
    endcase
  end

  assign show = (div_cnt >= GUARD_C) && !sel_blank;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      div_cnt  <= '0;
      digit    <= 2'd0;
      snap0    <= 7'd0;
      snap1    <= 7'd0;
      snap2    <= 7'd0;
      segs     <= 7'd0;
      digit_en <= 3'b000;
    end else begin
      div_cnt <= slot_end ? '0 : div_cnt + 1'b1;

      if (digit == 2'd3)
        digit <= 2'd0;
      else if (slot_end)
        digit <= (digit == 2'd2) ? 2'd0 : digit + 2'd1;

      if (frame_start) begin
        snap0 <= sec_ones_segs;
        snap1 <= sec_tens_segs;
        snap2 <= min_segs;
      end

      // Outputs follow the current-cycle state one cycle later; the capture
      // cycle is always inside the guard, so it never shows a stale code.
      if (show) begin
        digit_en <= sel_en;
        segs     <= sel_segs;
      end else begin
        digit_en <= 3'b000;
        segs     <= 7'd0;
      end
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
module tb_display_scanner;

  localparam int RD = 8;
  localparam int GD = 2;
  localparam int FRAME = 3 * RD;
  localparam logic [6:0] ZERO = 7'b0111111;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [6:0] ones = 7'd0, tens = 7'd0, mins = 7'd0;
  logic [6:0] segs_b, segs_n;
  logic [2:0] en_b, en_n;

  always #5 clock = ~clock;

  display_scanner #(.REFRESH_DIV(RD), .GUARD(GD), .BLANK_LEADING(1)) dut_b (
    .clock(clock), .resetn(resetn),
    .sec_ones_segs(ones), .sec_tens_segs(tens), .min_segs(mins),
    .segs(segs_b), .digit_en(en_b)
  );

  display_scanner #(.REFRESH_DIV(RD), .GUARD(GD), .BLANK_LEADING(0)) dut_n (
    .clock(clock), .resetn(resetn),
    .sec_ones_segs(ones), .sec_tens_segs(tens), .min_segs(mins),
    .segs(segs_n), .digit_en(en_n)
  );

  typedef struct packed {
    logic [6:0] segs_b;
    logic [2:0] en_b;
    logic [6:0] segs_n;
    logic [2:0] en_n;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model: t = cycles since the first cycle with resetn high.
  int         t = 0;
  logic [6:0] msnap[3];

  // Drive one cycle of stimulus and predict what both outputs will show
  // after the edge that ends this cycle.
  task automatic step(input logic rn, input logic [6:0] o, input logic [6:0] te, input logic [6:0] m);
    exp_t e;
    int   slot, pos;
    bit   bl1, bl2, blanked;
    @(negedge clock);
    resetn = rn; ones = o; tens = te; mins = m;
    e = '0;
    if (!rn) begin
      msnap[0] = 7'd0; msnap[1] = 7'd0; msnap[2] = 7'd0;
      t = 0;
    end else begin
      if (t % FRAME == 0) begin
        msnap[0] = o; msnap[1] = te; msnap[2] = m;
      end
      pos  = t % RD;
      slot = (t / RD) % 3;
      bl2  = (msnap[2] == ZERO);
      bl1  = bl2 && (msnap[1] == ZERO);
      blanked = (slot == 2 && bl2) || (slot == 1 && bl1);
      if (pos >= GD) begin
        e.en_n   = 3'(1 << slot);
        e.segs_n = msnap[slot];
        if (!blanked) begin
          e.en_b   = 3'(1 << slot);
          e.segs_b = msnap[slot];
        end
      end
      t++;
    end
    sb_q.push_back(e);
  endtask

  logic [6:0] co = 7'd0, ct = 7'd0, cm = 7'd0;

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, co, ct, cm);
  endtask

  task automatic run_until_phase(input int ph);
    int guard_cnt = 0;
    while ((t % FRAME) != ph && guard_cnt < 4 * FRAME) begin
      step(1'b1, co, ct, cm);
      guard_cnt++;
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, co, ct, cm);
  endtask

  // Monitor: compares every registered output against the scoreboard and
  // watches the one-hot / guard-gap invariant on the blanking instance.
  logic [2:0] last_en = 3'b000;
  int         off_cnt = 0;

  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if ({segs_b, en_b} !== {e.segs_b, e.en_b}) begin
          errors++;
          $display("FAIL blank_out cyc=%0d got segs=%h en=%b expected segs=%h en=%b",
                   cyc, segs_b, en_b, e.segs_b, e.en_b);
        end
        checks++;
        if ({segs_n, en_n} !== {e.segs_n, e.en_n}) begin
          errors++;
          $display("FAIL noblank_out cyc=%0d got segs=%h en=%b expected segs=%h en=%b",
                   cyc, segs_n, en_n, e.segs_n, e.en_n);
        end
      end
      checks++;
      if (!$onehot0(en_b)) begin
        errors++;
        $display("FAIL onehot cyc=%0d got en=%b expected zero or one-hot", cyc, en_b);
      end
      if (en_b != 3'b000) begin
        if (last_en != 3'b000 && en_b != last_en) begin
          checks++;
          if (off_cnt < GD) begin
            errors++;
            $display("FAIL guard_gap cyc=%0d got %0d off cycles between %b and %b expected >= %0d",
                     cyc, off_cnt, last_en, en_b, GD);
          end
        end
        last_en = en_b;
        off_cnt = 0;
      end else begin
        off_cnt++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset/startup and full display "1","2","3".
    co = 7'h06; ct = 7'h5B; cm = 7'h4F;
    do_reset(3);
    run(2 * FRAME);

    // Mid-frame change at t%FRAME == 10: old codes persist to frame end.
    run_until_phase(10);
    co = 7'h7D; ct = 7'h07; cm = 7'h7F;
    run(FRAME);

    // Change exactly in the capture cycle: new values are captured.
    run_until_phase(0);
    co = 7'h66; ct = 7'h6D; cm = 7'h06;
    run(FRAME + 4);

    // Leading-zero blanking: two leading zeros, then one.
    run_until_phase(5);
    co = 7'h6D; ct = ZERO; cm = ZERO;
    run(2 * FRAME);
    run_until_phase(7);
    co = 7'h3F; ct = 7'h66; cm = ZERO;
    run(2 * FRAME);

    // Reset during slot 1 at div_cnt = 4, then restart with fresh capture.
    co = 7'h06; ct = 7'h5B; cm = 7'h4F;
    run_until_phase(RD + 4);
    do_reset(2);
    co = 7'h4F; ct = 7'h06; cm = 7'h5B;
    run(2 * FRAME);

    // Randomised inputs with occasional resets.
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        co = 7'($urandom);
        ct = ($urandom_range(0, 1) == 0) ? ZERO : 7'($urandom);
        cm = ($urandom_range(0, 1) == 0) ? ZERO : 7'($urandom);
      end
      step(($urandom_range(0, 1999) != 0), co, ct, cm);
    end

    @(posedge clock);
    #3;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexes the three seven-segment codes produced by the microwave's digit decoder onto one shared segment bus with one-hot digit enables, for a common-segment multiplexed panel. Sits directly downstream of the decoder stage, between the `sec_ones_segs`/`sec_tens_segs`/`min_segs` nets and the board pins. Adds three things:
- frame-coherent snapshotting, so a frame never mixes old and new codes;
- leading-zero blanking;
- an anti-ghosting guard interval at the start of each digit slot.

## Interface
Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot. Must satisfy 4 ≤ REFRESH_DIV ≤ 2^20.
- GUARD, 4: cycles at the start of each slot with all digits off. Must satisfy 2 ≤ GUARD < REFRESH_DIV.
- BLANK_LEADING, 1: 1 enables leading-zero blanking; 0 always displays all digits.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  reset. Synchronous and active-low.
- sec_ones_segs  in  7  segment code for digit 0, gfedcba, active-high.
- sec_tens_segs  in  7  segment code for digit 1.
- min_segs  in  7  segment code for digit 2.
- segs  out  7  shared segment bus, gfedcba, active-high.
- digit_en  out  3  one-hot digit enable, active-high. Bit0 is sec_ones, bit1 is sec_tens, bit2 is min.

## Operation
- div_cnt: counts 0..REFRESH_DIV-1, then wraps to 0.
- digit: 2-bit ring, sequence 0→1→2→0. It advances only on the cycle where div_cnt == REFRESH_DIV-1. Value 3 is unreachable; if it ever occurs, the next cycle forces digit to 0.
- Snapshot:
  - snap0/snap1/snap2 (7 bits each) load sec_ones_segs/sec_tens_segs/min_segs on every cycle where digit == 0 and div_cnt == 0 (start of frame).
  - This includes the first cycle after resetn deasserts.
  - Between captures, input changes have no effect on the output.
- Blanking (BLANK_LEADING = 1). ZERO = 7'b0111111.
  - blank2 = (snap2 == ZERO).
  - blank1 = blank2 and (snap1 == ZERO).
  - Digit 0 is never blanked.
  - With BLANK_LEADING = 0, blank1 = blank2 = 0.
- Output registers, updated every cycle from the current-cycle state:
  - If div_cnt < GUARD, or the selected digit is blanked: digit_en ← 0 and segs ← 0.
  - Otherwise: digit_en ← onehot(digit) and segs ← snap[digit].
- Reset (resetn low at a rising edge): div_cnt = 0, digit = 0, snap0..2 = 0, segs = 0, digit_en = 0.
  - Reset mid-slot aborts the scan immediately.
  - Scanning restarts at digit 0 with a fresh capture on the first cycle with resetn high.
- Inputs are decoder outputs and are treated as synchronous to clock. The block has no synchronizers.

## Timing
- The output registers lag the counter state by 1 cycle.
- Taking cycle 0 as the first cycle with resetn high:
  - The capture happens in cycle 0.
  - digit_en stays 0 through cycle GUARD.
  - digit_en[0] first asserts after the edge ending cycle GUARD, i.e. it is visible during cycle GUARD+1.
- Slot k spans cycles k·REFRESH_DIV .. (k+1)·REFRESH_DIV-1 of its frame. digit_en for that slot is high for exactly REFRESH_DIV-GUARD cycles.
- Frame period is 3·REFRESH_DIV cycles. Input-to-display latency is at most 3·REFRESH_DIV + GUARD + 1 cycles.
- At most one digit_en bit is high in any cycle. A transition between two enables always has ≥ GUARD all-off cycles between them.
- Inputs that change in the same cycle as the capture are captured with their new value, as presented at that edge.
- The three codes are always displayed from the same capture within one frame.

## Test plan
Use REFRESH_DIV = 8 and GUARD = 2 unless stated otherwise.
1. Reset/startup: hold resetn low for 3 cycles, then release.
   - Outputs are 0 while held low.
   - digit_en = 3'b001 first appears at cycle 3 after release.
   - digit_en sequence is 001 (6 cycles), 000 (2), 010 (6), 000 (2), 100 (6), then repeats.
2. Full display, inputs 7'h06/7'h5B/7'h4F (digits "1", "2", "3"):
   - segs shows 06 with en 001, 5B with en 010, and 4F with en 100.
   - segs is 0 during every guard cycle.
3. Leading-zero blanking:
   - min = ZERO, tens = ZERO, ones = 7'h6D: only slot 0 enables; slots 1 and 2 output 000/0.
   - min = ZERO, tens = 7'h66: slot 1 enables and slot 2 is blank.
   - With BLANK_LEADING = 0, all three slots enable.
4. Snapshot coherency: change all inputs mid-frame at cycle 10.
   - The current frame still shows the old codes in slot 2.
   - New codes appear starting at the next frame's slot 0.
   - An input change in the capture cycle itself is captured at that edge.
5. Reset mid-operation: assert resetn during slot 1 at div_cnt = 4.
   - Outputs are 0 the next cycle.
   - After release, the scan restarts at digit 0 with a fresh capture; there is no residual slot-1 enable.
6. Invariant check (randomised inputs, 10^4 cycles): digit_en is always 0 or one-hot, with ≥ 2 all-off cycles between distinct enables.
